// File: rtl/mult_prod_accumulator.sv
// mult_prod_accumulator
// Collects unsigned product words from the 4x4 tree multiplier through a
// valid/ready handshake. It sums a group of terms and presents the group's
// sum, term count and sticky overflow flag on a valid/ready result port.
// A group closes on in_last or when MAX_TERMS terms have been accepted,
// whichever comes first. While a result is held, no new terms are accepted.
module mult_prod_accumulator #(
  parameter int PROD_W    = 8,
  parameter int ACC_W     = 16,
  parameter int MAX_TERMS = 16,
  parameter int CNT_W     = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_ovf
);

  typedef enum logic {
    ACC  = 1'b0,
    DONE = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               ovf_q, ovf_d;

  logic               accept;
  logic [ACC_W:0]     sumExt;
  logic [CNT_W-1:0]   countInc;
  logic               closeGroup;

  // Handshake qualifiers and the widened add. The extra top bit of sumExt
  // is the carry out of bit ACC_W-1, which feeds the sticky overflow flag.
  always_comb begin
    in_ready   = (state_q == ACC) && !rst;
    accept     = in_valid && in_ready;
    sumExt     = {1'b0, acc_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, in_prod};
    countInc   = count_q + CNT_W'(1);
    closeGroup = in_last || (countInc == CNT_W'(MAX_TERMS));
  end

  // The result port mirrors the held accumulator only while a result is
  // pending. It reads zero otherwise, so it changes only on entering DONE.
  always_comb begin
    out_valid = (state_q == DONE);
    out_sum   = out_valid ? acc_q   : '0;
    out_count = out_valid ? count_q : '0;
    out_ovf   = out_valid ? ovf_q   : 1'b0;
  end

  // Next-state logic. Terms are accepted only in ACC. DONE holds everything
  // until the consumer takes the result, and then clears for the next group.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    case (state_q)
      ACC: begin
        if (accept) begin
          acc_d   = sumExt[ACC_W-1:0];
          ovf_d   = ovf_q | sumExt[ACC_W];
          count_d = countInc;
          if (closeGroup) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = ACC;
          acc_d   = '0;
          count_d = '0;
          ovf_d   = 1'b0;
        end
      end
      default: begin
        state_d = ACC;
      end
    endcase
  end

  // State and datapath registers. The synchronous reset overrides any
  // handshake in the same cycle, including one that occurs mid-group.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACC;
      acc_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_mult_prod_accumulator.sv
// tb_mult_prod_accumulator
// Drives two accumulators from identical stimulus: one with the default
// 16-bit sum and one with an 8-bit sum, which makes wrap and overflow
// reachable. A behavioural model tracks the true unbounded group total.
// It derives each width's expected sum as the total modulo 2^W. Because
// the running total only grows, a carry out of the top bit has happened
// exactly when that total reaches 2^W.
module tb_mult_prod_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        inValid;
  logic [7:0]  inProd;
  logic        inLast;
  logic        outReady;

  logic        readyA, validA, ovfA;
  logic [15:0] sumA;
  logic [4:0]  countA;
  logic        readyB, validB, ovfB;
  logic [7:0]  sumB;
  logic [4:0]  countB;

  int checks   = 0;
  int failures = 0;
  bit checking = 1'b0;

  // Behavioural model state
  longint mTotal = 0;
  int     mCount = 0;
  bit     mDone  = 1'b0;

  always #5 clk = ~clk;

  mult_prod_accumulator dutA (
    .clk(clk), .rst(rst),
    .in_valid(inValid), .in_ready(readyA), .in_prod(inProd), .in_last(inLast),
    .out_valid(validA), .out_ready(outReady),
    .out_sum(sumA), .out_count(countA), .out_ovf(ovfA)
  );

  mult_prod_accumulator #(.ACC_W(8)) dutB (
    .clk(clk), .rst(rst),
    .in_valid(inValid), .in_ready(readyB), .in_prod(inProd), .in_last(inLast),
    .out_valid(validB), .out_ready(outReady),
    .out_sum(sumB), .out_count(countB), .out_ovf(ovfB)
  );

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs shortly after the rising edge
  task automatic applyStimulus(input bit r, input bit v, input logic [7:0] p,
                               input bit l, input bit ordy);
    @(posedge clk);
    #1;
    rst      = r;
    inValid  = v;
    inProd   = p;
    inLast   = l;
    outReady = ordy;
  endtask

  // Model: a group is a list of accepted terms. It closes on last or on
  // the 16th term, and it is released by the consumer.
  always @(posedge clk) begin
    if (rst) begin
      mTotal = 0;
      mCount = 0;
      mDone  = 1'b0;
    end else if (!mDone) begin
      if (inValid) begin
        mTotal = mTotal + inProd;
        mCount = mCount + 1;
        if (inLast || mCount == 16) mDone = 1'b1;
      end
    end else if (outReady) begin
      mTotal = 0;
      mCount = 0;
      mDone  = 1'b0;
    end
  end

  // Compare both instances against the model every cycle, mid-cycle
  always @(negedge clk) begin
    if (checking) begin
      checkOutput("readyA", readyA, (!rst && !mDone));
      checkOutput("validA", validA, mDone);
      checkOutput("sumA",   sumA,   mDone ? (mTotal % 65536) : 0);
      checkOutput("countA", countA, mDone ? mCount : 0);
      checkOutput("ovfA",   ovfA,   (mDone && mTotal >= 65536));
      checkOutput("readyB", readyB, (!rst && !mDone));
      checkOutput("validB", validB, mDone);
      checkOutput("sumB",   sumB,   mDone ? (mTotal % 256) : 0);
      checkOutput("countB", countB, mDone ? mCount : 0);
      checkOutput("ovfB",   ovfB,   (mDone && mTotal >= 256));
    end
  end

  initial begin
    rst = 1'b1; inValid = 1'b1; inProd = 8'hFF; inLast = 1'b0; outReady = 1'b0;
    @(posedge clk);
    #1 checking = 1'b1;

    // Reset with a pending product: it must never be accepted
    @(negedge clk);
    checkOutput("lit_reset_ready", readyA, 0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("lit_post_reset_valid", validA, 0);
    checkOutput("lit_post_reset_ready", readyA, 1);

    // Basic group: 3*3 + 7*7 + 15*15
    applyStimulus(1'b0, 1'b1, 8'h09, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 8'h31, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 8'hE1, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("lit_basic_valid", validA, 1);
    checkOutput("lit_basic_sumA",  sumA,   16'h011B);
    checkOutput("lit_basic_count", countA, 3);
    checkOutput("lit_basic_ovfA",  ovfA,   0);
    checkOutput("lit_basic_sumB",  sumB,   8'h1B);
    checkOutput("lit_basic_ovfB",  ovfB,   1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

    // Auto close after 16 terms, followed by backpressure with in_valid held
    for (int i = 0; i < 16; i++) applyStimulus(1'b0, 1'b1, 8'hE1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'hE1, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("lit_auto_ready", readyA, 0);
    checkOutput("lit_auto_sumA",  sumA,   16'h0E10);
    checkOutput("lit_auto_count", countA, 16);
    checkOutput("lit_auto_ovfA",  ovfA,   0);
    checkOutput("lit_auto_sumB",  sumB,   8'h10);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 8'hE1, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("lit_bp_sumA",  sumA,   16'h0E10);
    checkOutput("lit_bp_count", countA, 16);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("lit_release_valid", validA, 0);
    checkOutput("lit_release_ready", readyA, 1);

    // Overflow on the 8-bit instance, then a clean group afterwards
    applyStimulus(1'b0, 1'b1, 8'hE1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'h40, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("lit_ovf_sumB",  sumB,   8'h21);
    checkOutput("lit_ovf_count", countB, 2);
    checkOutput("lit_ovf_ovfB",  ovfB,   1);
    checkOutput("lit_ovf_sumA",  sumA,   16'h0121);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'h05, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("lit_clean_sumB", sumB, 8'h05);
    checkOutput("lit_clean_ovfB", ovfB, 0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

    // Reset mid-group discards the partial sum, even with a term offered
    applyStimulus(1'b0, 1'b1, 8'hE1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'hE1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 8'hE1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'h04, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("lit_midrst_sumA",  sumA,   16'h0004);
    checkOutput("lit_midrst_count", countA, 1);
    checkOutput("lit_midrst_ovfA",  ovfA,   0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    checking = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/mult_prod_accumulator.md
Name: mult_prod_accumulator

Overview:
- Downstream consumer of the combinational 4x4 tree multiplier.
- Takes the 8-bit product word through a valid/ready handshake and accumulates a group of products into a wide sum.
- Presents each group's sum, term count and an overflow flag on a valid/ready output port.
- Used to build dot-product and MAC tests around the generated multiplier netlists.

Parameters:
PROD_W, 8, width of the incoming product (multiplier output o)
ACC_W, 16, accumulator and output sum width; must be >= PROD_W
MAX_TERMS, 16, maximum products per group; group closes automatically at this count
CNT_W, 5, term counter width; must satisfy 2^CNT_W > MAX_TERMS

Ports:
clk  input  1  single clock, rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  product word valid
in_ready  output  1  block can accept a product this cycle
in_prod  input  PROD_W  unsigned product from multiplier output o
in_last  input  1  accepted word is the last term of the group
out_valid  output  1  group result available
out_ready  input  1  consumer takes result this cycle
out_sum  output  ACC_W  accumulated sum of the group, modulo 2^ACC_W
out_count  output  CNT_W  number of terms in the group
out_ovf  output  1  sticky: a carry left bit ACC_W-1 during this group

Behaviour:
- States: ACC (accepting terms) and DONE (holding a result). Reset state is ACC.
- Reset (sampled on clk while rst=1):
  - State becomes ACC; accumulator, counter and overflow flag become 0.
  - out_valid=0, out_sum=0, out_count=0, out_ovf=0.
  - in_ready is forced 0 while rst is high.
  - An in_valid during reset is never accepted.
  - Reset overrides any handshake in the same cycle, including mid-group.
- in_ready is 1 exactly when state==ACC and rst==0. It is a function of state and rst only and never depends on in_valid.
- Accept occurs when in_valid and in_ready are both 1. On an accept:
  - acc <= acc + zero-extended in_prod (unsigned, truncated to ACC_W).
  - The carry out of bit ACC_W-1 is ORed into the sticky ovf.
  - count <= count + 1.
- Group close: a group closes on an accept where in_last=1 or where the new count equals MAX_TERMS. On close, the next state is DONE, and out_sum, out_count and out_ovf include the closing term.
- Latency: out_valid rises on the clock edge after the closing accept, which is 1 cycle.
- DONE:
  - out_valid=1 and in_ready=0.
  - out_sum, out_count and out_ovf hold stable until the output handshake.
  - in_valid and in_last are ignored.
- Output handshake occurs when out_valid and out_ready are both 1. On the next edge:
  - acc, count and ovf clear to 0 and state returns to ACC.
  - out_valid falls to 0.
  - in_ready is 1 in the following cycle, so there is one bubble between groups.
- out_sum, out_count and out_ovf read 0 while out_valid=0. They are updated only when entering DONE.
- Empty groups cannot occur, because a group always closes on an accepted term.
- in_last on the first term gives a single-term group.
- MAX_TERMS has priority regardless of in_last: at count==MAX_TERMS the group closes with in_last ignored.
- The counter never wraps, because the group closes at MAX_TERMS.
- Accumulator wrap is modulo 2^ACC_W. The stored sum keeps the low ACC_W bits and out_ovf=1.
- X on in_prod or in_last while in_valid=0 must not affect state.

Test Plan:
- Reset: rst=1 for 2 cycles with in_valid=1, in_prod=0xFF -> in_ready=0, no accept. After release: out_valid=0, out_sum=0, out_count=0, first accept starts at acc=0.
- Basic group: the multiplier drives 3*3, 7*7 and 15*15 (in_prod 0x09, 0x31, 0xE1), in_last on the third, out_ready=1 -> 1 cycle later out_valid=1, out_sum=0x011B (283), out_count=3, out_ovf=0.
- Auto close: 16 back-to-back terms of 0xE1, in_last=0 -> in_ready=0 after the 16th accept, out_sum=0x0E10 (3600), out_count=16, out_ovf=0.
- Backpressure: out_ready=0 for 5 cycles while in DONE, in_valid=1 -> out_* stable and no accepts. Then out_ready=1 for 1 cycle -> out_valid=0 next cycle, in_ready=1, next group starts from acc=0.
- Overflow (ACC_W=8): terms 0xE1 then 0x40 with last -> out_sum=0x21, out_count=2, out_ovf=1. The next group, 0x05 with last, gives out_ovf=0.
- Reset mid-group: after 2 accepts of 0xE1, pulse rst for 1 cycle, then send 0x04 with last -> out_sum=0x0004, out_count=1, out_ovf=0.
